// File: rtl/bist_fault_collector.sv
// bist_fault_collector
//   Collects fault events from the runtime ALU BIST controller. Each rising
//   edge of the BIST error level (while enabled) bumps a saturating fault
//   counter, logs an {alu_result, timestamp} snapshot into a small FIFO and
//   drives a three-state IDLE/ALERT/ESCALATED alert machine. Software
//   inspects and clears everything through a zero-wait-state APB slave.
//
//   Optional feature: define BIST_FAULT_TIMESTAMP_EN to add a free-running
//   16-bit cycle counter captured with each log entry. Without it the
//   counter does not exist and LOG_TS reads 0.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   bist_error_irq_i      level error from the BIST controller
//   alu_result_i          snapshot data captured on each event
//   paddr_i .. pwdata_i   APB slave request
//   prdata_o, pready_o    APB read data / ready (always ready)
//   fault_alert_o         FSM in ALERT or ESCALATED
//   safe_state_req_o      FSM in ESCALATED
//
// Register map (paddr_i[4:2])
//   0x00 STATUS   RO  [0] alert [1] escalated [2] empty [3] full [4] overflow [15:8] count
//   0x04 CTRL     RW  [0] enable [7:4] threshold (0 written reads back as 1)
//   0x08 LOG_DATA RO  head snapshot, read pops
//   0x0C LOG_TS   RO  [15:0] head timestamp
//   0x10 CLEAR    WO  [0] clear count/overflow, leave ALERT; [1] leave ESCALATED
module bist_fault_collector #(
   parameter int FIFO_DEPTH    = 4,
   parameter int ESC_THRESHOLD = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        bist_error_irq_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] paddr_i,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic        pwrite_i,
   input  logic [31:0] pwdata_i,
   output logic [31:0] prdata_o,
   output logic        pready_o,
   output logic        fault_alert_o,
   output logic        safe_state_req_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ALERT, S_ESC} state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [15:0] ts;
   } entry_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic        en_q, en_d;
   logic [3:0]  thr_q, thr_d;
   logic        irq_q, irq_d;
   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   entry_t      mem_q [FIFO_DEPTH];
   entry_t      mem_d [FIFO_DEPTH];
   logic [15:0] ts_cur;

`ifdef BIST_FAULT_TIMESTAMP_EN
   logic [15:0] ts_q, ts_d;
   assign ts_d   = ts_q + 16'd1;   // wraps 0xFFFF -> 0 naturally
   assign ts_cur = ts_q;
`else
   assign ts_cur = 16'd0;
`endif

   logic        access, rd, wr, empty, full, fault_evt, pop, push;
   logic [2:0]  reg_sel;
   logic [1:0]  clr;
   entry_t      head;
   logic [31:0] status;
   logic        unused_apb;

   assign access  = psel_i & penable_i;
   assign rd      = access & ~pwrite_i;
   assign wr      = access & pwrite_i;
   assign reg_sel = paddr_i[4:2];

   // Extra pointer bit: equal pointers mean empty, equal index with
   // differing wrap bit means full.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign fault_evt = bist_error_irq_i & ~irq_q & en_q;
   assign pop       = rd & (reg_sel == 3'd2) & ~empty;
   // A pop in the same cycle frees the slot the push needs.
   assign push      = fault_evt & (~full | pop);
   assign clr       = (wr && reg_sel == 3'd4) ? pwdata_i[1:0] : 2'b00;
   assign irq_d     = bist_error_irq_i;
   assign head      = mem_q[rptr_q[AW-1:0]];

   assign unused_apb = ^{paddr_i[31:5], paddr_i[1:0], pwdata_i[31:8], pwdata_i[3:2]};

   always_comb begin
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      state_d = state_q;
      en_d    = en_q;
      thr_d   = thr_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      mem_d   = mem_q;

      // Clears are applied first so a coincident event wins.
      if (clr[0] | clr[1]) cnt_d = 8'd0;
      if (clr[0]) ovf_d = 1'b0;
      if (clr[0] && state_q == S_ALERT) state_d = S_IDLE;
      if (clr[1] && state_q == S_ESC)   state_d = S_IDLE;

      if (fault_evt) begin
         if (cnt_d != 8'hFF) cnt_d = cnt_d + 8'd1;
         if (cnt_d >= {4'd0, thr_q})   state_d = S_ESC;
         else if (state_d == S_IDLE)   state_d = S_ALERT;
         if (full && !pop) ovf_d = 1'b1;
      end

      if (push) begin
         mem_d[wptr_q[AW-1:0]] = '{data: alu_result_i, ts: ts_cur};
         wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop) rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};

      if (wr && reg_sel == 3'd1) begin
         en_d  = pwdata_i[0];
         thr_d = (pwdata_i[7:4] == 4'd0) ? 4'd1 : pwdata_i[7:4];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         ovf_q   <= 1'b0;
         en_q    <= 1'b1;
         thr_q   <= 4'(ESC_THRESHOLD);
         irq_q   <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
`ifdef BIST_FAULT_TIMESTAMP_EN
         ts_q    <= 16'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         en_q    <= en_d;
         thr_q   <= thr_d;
         irq_q   <= irq_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
`ifdef BIST_FAULT_TIMESTAMP_EN
         ts_q    <= ts_d;
`endif
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign fault_alert_o    = (state_q == S_ALERT) || (state_q == S_ESC);
   assign safe_state_req_o = (state_q == S_ESC);
   assign pready_o         = 1'b1;

   assign status = {16'd0, cnt_q, 3'd0, ovf_q, full, empty, safe_state_req_o, fault_alert_o};

   always_comb begin
      prdata_o = 32'd0;
      if (access) begin
         case (reg_sel)
            3'd0:    prdata_o = status;
            3'd1:    prdata_o = {24'd0, thr_q, 3'd0, en_q};
            3'd2:    prdata_o = empty ? 32'd0 : head.data;
            3'd3:    prdata_o = empty ? 32'd0 : {16'd0, head.ts};
            default: prdata_o = 32'd0;
         endcase
      end
   end

endmodule

// File: doc/bist_fault_collector.md
BIST_FAULT_COLLECTOR -- requirements
Module: bist_fault_collector

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, fault-log entries (power of two, 2..16).
REQ-002 SHALL have parameter ESC_THRESHOLD, default 3, reset value of the escalation threshold (1..15).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port bist_error_irq_i  input  1  level error from the runtime BIST controller of the ALU BIST wrapper.
REQ-006 SHALL have port alu_result_i  input  32  ALU result, sampled as the fault snapshot.
REQ-007 SHALL have ports paddr_i  input  32, psel_i, penable_i, pwrite_i  input  1 each, and pwdata_i  input  32, forming an APB slave.
REQ-008 SHALL have ports prdata_o  output  32 and pready_o  output  1, the APB read data and ready.
REQ-009 SHALL have port fault_alert_o  output  1  high while the FSM is in ALERT or ESCALATED.
REQ-010 SHALL have port safe_state_req_o  output  1  high only in ESCALATED.

Function
REQ-011 Fault event: a 0->1 edge of bist_error_irq_i, detected against a registered copy, while CTRL.enable=1; a held level counts as one event.
REQ-012 On each event:
- fault_count (8-bit) SHALL increment, saturating at 255.
- The collector SHALL push {alu_result_i, timestamp} into the FIFO in the same cycle.
REQ-013 Push when the FIFO is full:
- The entry SHALL be dropped and sticky overflow set.
- If a pop occurs in the same cycle, the push SHALL succeed and overflow SHALL stay unchanged.
REQ-014 The FSM SHALL have three states:
- IDLE -> ALERT on an event.
- ALERT -> ESCALATED when the updated fault_count >= CTRL.threshold.
- ESCALATED is sticky until CLEAR bit1.
- An event that reaches the threshold directly from IDLE SHALL go straight to ESCALATED.
REQ-015 CLEAR write:
- Bit0 SHALL zero fault_count and overflow and move ALERT->IDLE.
- Bit1 SHALL move ESCALATED->IDLE and also zero fault_count.
- An event in the same cycle SHALL win: count=1, state ALERT.
REQ-016 APB transfers SHALL complete in the access phase (psel_i & penable_i) with pready_o=1 and zero wait states; paddr_i[4:2] SHALL decode the registers.
REQ-017 Register map:
- 0x00 STATUS (RO): [0] alert, [1] escalated, [2] fifo_empty, [3] fifo_full, [4] overflow, [15:8] fault_count.
- 0x04 CTRL (RW): [0] enable, reset 1; [7:4] threshold, reset ESC_THRESHOLD. A written threshold of 0 SHALL be treated as 1.
- 0x08 LOG_DATA (RO): head snapshot; the read SHALL pop.
- 0x0C LOG_TS (RO): [15:0] head timestamp; no pop.
- 0x10 CLEAR (WO).
REQ-018 A LOG_DATA read on an empty FIFO SHALL return 0 and SHALL not change state.
REQ-019 LOG_TS SHALL reflect the head entry before the pop caused by the same access.
REQ-020 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored.
REQ-021 prdata_o SHALL be combinational from the current state during the access phase and 0 otherwise.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-023 With rst_i high at a clock edge, the block SHALL set:
- FSM=IDLE and fault_count=0.
- overflow=0 and FIFO empty.
- enable=1 and threshold=ESC_THRESHOLD.
- timestamp=0 and the irq edge register=0.
- fault_alert_o=0 and safe_state_req_o=0.
REQ-024 Reset mid-operation SHALL discard FIFO contents and any in-flight APB access; an irq held high across reset release SHALL count as an event one cycle after release.

Configuration
REQ-025 The macro BIST_FAULT_TIMESTAMP_EN SHALL select the timestamp feature.
- Defined: a free-running 16-bit cycle counter, wrapping 0xFFFF->0, SHALL be captured with each entry.
- Undefined: the counter SHALL be absent and LOG_TS SHALL read 0.

Verification
REQ-026 Reset, then a single irq pulse with alu_result_i=0xDEADBEEF: STATUS=0x0000_0101 (count 1, alert), fault_alert_o=1, and a LOG_DATA read returns 0xDEADBEEF, after which STATUS[2]=1.
REQ-027 Threshold 3, three pulses: safe_state_req_o rises the cycle after the third edge; CLEAR=0x1 leaves ESCALATED; CLEAR=0x2 returns IDLE with count 0.
REQ-028 Six pulses with FIFO_DEPTH=4 and no reads: fifo_full=1, overflow=1, and four pops return the first four snapshots in order.
REQ-029 Irq held high for 20 cycles: count=1 only; with CTRL.enable=0, a pulse leaves count and FIFO unchanged.
REQ-030 CLEAR=0x1 written in the same cycle as an irq edge: count=1, state ALERT; with the macro defined, an event at timestamp 0xFFFF followed by one 2 cycles later logs 0x0001.
